// File: rtl/sdf_path_delay_monitor.sv
// Measures sel-to-zout delay of a conditional-path cell, split by
// rise/fall and by the mode condition latched at the sel edge.
module sdf_path_delay_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             sel,
  input  logic             zout,
  input  logic             clr,
  output logic [CNT_W-1:0] rise_m0,
  output logic [CNT_W-1:0] fall_m0,
  output logic [CNT_W-1:0] rise_m1,
  output logic [CNT_W-1:0] fall_m1,
  output logic [3:0]       valid,
  output logic             done,
  output logic             timeout,
  output logic             rejected,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state_q;

  logic mode_q;
  logic sel_q;
  logic sel_p;
  logic zout_q;
  logic zout_p;
  logic tgt_q;
  logic cond_q;
  logic done_q;
  logic tmo_q;
  logic rej_q;

  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       valid_q;
  logic [3:0][CNT_W-1:0] res_q;

  logic             sel_edge;
  logic             zout_edge;
  logic             hit_new;
  logic             hit_cur;
  logic             in_meas;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_to;
  logic             wr_en;
  logic [1:0]       wr_idx;
  logic [CNT_W-1:0] wr_val;

  assign sel_edge  = sel_q ^ sel_p;
  assign zout_edge = zout_q ^ zout_p;
  assign in_meas   = (state_q == MEASURE);
  assign hit_new   = zout_edge && (zout_q == sel_q);
  assign hit_cur   = zout_edge && (zout_q == tgt_q);
  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign at_to     = (cnt_nxt == CNT_W'(TIMEOUT));

  // A fresh sel edge pre-empts the running measurement; its own
  // same-cycle matching zout edge records a zero delay.
  assign wr_en  = sel_edge ? hit_new : (in_meas && hit_cur);
  assign wr_idx = sel_edge ? {mode_q, ~sel_q} : {cond_q, ~tgt_q};
  assign wr_val = sel_edge ? '0 : cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= mode;
      sel_q   <= sel;
      sel_p   <= sel;
      zout_q  <= zout;
      zout_p  <= zout;
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      cond_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      mode_q <= mode;
      sel_q  <= sel;
      sel_p  <= sel_q;
      zout_q <= zout;
      zout_p <= zout_q;

      done_q <= wr_en;
      rej_q  <= sel_edge && in_meas;
      tmo_q  <= !sel_edge && in_meas && !hit_cur && at_to;

      if (clr) begin
        res_q   <= '0;
        valid_q <= '0;
      end
      if (wr_en) begin
        res_q[wr_idx]   <= wr_val;
        valid_q[wr_idx] <= 1'b1;
      end

      if (sel_edge) begin
        tgt_q   <= sel_q;
        cond_q  <= mode_q;
        cnt_q   <= '0;
        state_q <= hit_new ? IDLE : MEASURE;
      end else if (in_meas) begin
        cnt_q <= cnt_nxt;
        if (hit_cur || at_to) begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign rise_m0  = res_q[0];
  assign fall_m0  = res_q[1];
  assign rise_m1  = res_q[2];
  assign fall_m1  = res_q[3];
  assign valid    = valid_q;
  assign done     = done_q;
  assign timeout  = tmo_q;
  assign rejected = rej_q;
  assign busy     = (state_q == MEASURE);

endmodule
